id_inst_queue: RTL and testbench

- Parametrised instruction queue between the icache response (IC) and the ID decode register.
- Replaces the single-entry stall-capture latch with a DEPTH-entry circular buffer that accepts up to IN_W instructions per cycle and issues one per cycle to ID.
- Each entry carries {exc, pc, inst}.
- Supports exception flush, and branch kill with an optional delay-slot keep.

---
 rtl/id_inst_queue_pkg.sv | 19 +
 rtl/id_iq_ram.sv | 46 ++++
 rtl/id_inst_queue.sv | 162 ++++++++++++++++
 tb/tb_id_inst_queue.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_inst_queue_pkg.sv
// Shared sizing constants and per-cycle action encoding for the ID instruction queue.
// Entry layout (MSB..LSB): {exc, pc, inst}.
package id_inst_queue_pkg;

   localparam int unsigned IQ_DEPTH    = 8;
   localparam int unsigned IQ_IN_W     = 2;
   localparam int unsigned IQ_PC_W     = 32;
   localparam int unsigned IQ_INST_W   = 32;
   localparam int unsigned IQ_EXC_W    = 32;
   localparam int unsigned IQ_ENTRY_WD = IQ_EXC_W + IQ_PC_W + IQ_INST_W;

   // What the queue does with its pointers this cycle (rst is handled by the register itself)
   typedef enum logic [1:0] {
      IQ_ACT_NORMAL = 2'd0,
      IQ_ACT_CLEAR  = 2'd1,
      IQ_ACT_KEEP   = 2'd2
   } iq_act_e;

endpackage

// File: rtl/id_iq_ram.sv
// DEPTH x ENTRY_W register array for the ID instruction queue.
// Ports:
//   clk        clock
//   i_we       per-lane write enable; lane i writes index i_wr_idx+i (mod DEPTH)
//   i_wr_idx   base write index
//   i_wr_data  lane-packed write entries
//   i_mv_en    copy entry i_mv_src into index 0 (delay-slot compaction)
//   i_mv_src   source index of the copy
//   i_rd_idx   asynchronous read index
//   o_rd_data  entry at i_rd_idx
module id_iq_ram
   import id_inst_queue_pkg::*;
#(
   parameter int unsigned DEPTH   = IQ_DEPTH,
   parameter int unsigned IN_W    = IQ_IN_W,
   parameter int unsigned ENTRY_W = IQ_ENTRY_WD
) (
   input  logic                       clk,
   input  logic [IN_W-1:0]            i_we,
   input  logic [$clog2(DEPTH)-1:0]   i_wr_idx,
   input  logic [IN_W*ENTRY_W-1:0]    i_wr_data,
   input  logic                       i_mv_en,
   input  logic [$clog2(DEPTH)-1:0]   i_mv_src,
   input  logic [$clog2(DEPTH)-1:0]   i_rd_idx,
   output logic [ENTRY_W-1:0]         o_rd_data
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [ENTRY_W-1:0] r_mem [DEPTH];

   // Data array carries no reset; the move and lane writes never target the same cycle
   always_ff @(posedge clk) begin
      if (i_mv_en) begin
         r_mem[0] <= r_mem[i_mv_src];
      end
      for (int i = 0; i < int'(IN_W); i++) begin
         if (i_we[i]) begin
            r_mem[i_wr_idx + IDX_W'(i)] <= i_wr_data[i*ENTRY_W +: ENTRY_W];
         end
      end
   end

   assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/id_inst_queue.sv
// Instruction queue between the icache response and the ID decode register.
// Accepts up to IN_W instructions per cycle, issues one per cycle, supports
// exception flush and branch kill with optional delay-slot retention.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             discard everything
//   br_kill           discard wrong-path entries
//   br_keep_head      with br_kill: keep the post-pop head (delay slot)
//   in_valid/pc/inst/exc  lane-packed push group, lane 0 oldest
//   in_ready          room for a full IN_W group (registered count only)
//   out_valid/pc/inst/exc head entry, zero when empty
//   out_ready         ID accepts head
//   count, empty      occupancy
module id_inst_queue
   import id_inst_queue_pkg::*;
#(
   parameter int unsigned DEPTH  = IQ_DEPTH,
   parameter int unsigned IN_W   = IQ_IN_W,
   parameter int unsigned PC_W   = IQ_PC_W,
   parameter int unsigned INST_W = IQ_INST_W,
   parameter int unsigned EXC_W  = IQ_EXC_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      br_kill,
   input  logic                      br_keep_head,
   input  logic [IN_W-1:0]           in_valid,
   input  logic [IN_W*PC_W-1:0]      in_pc,
   input  logic [IN_W*INST_W-1:0]    in_inst,
   input  logic [IN_W*EXC_W-1:0]     in_exc,
   output logic                      in_ready,
   output logic                      out_valid,
   output logic [PC_W-1:0]           out_pc,
   output logic [INST_W-1:0]         out_inst,
   output logic [EXC_W-1:0]          out_exc,
   input  logic                      out_ready,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      empty
);

   localparam int unsigned IDX_W   = $clog2(DEPTH);
   localparam int unsigned PTR_W   = IDX_W + 1;
   localparam int unsigned ENTRY_W = EXC_W + PC_W + INST_W;

   logic [PTR_W-1:0]          r_rd_ptr;
   logic [PTR_W-1:0]          r_wr_ptr;
   logic [PTR_W-1:0]          w_rd_nxt;
   logic [PTR_W-1:0]          w_wr_nxt;
   logic [PTR_W-1:0]          w_count;
   logic [PTR_W-1:0]          w_free;
   logic [PTR_W-1:0]          w_push_n;
   logic [PTR_W-1:0]          w_pop_ptr;
   logic [IN_W-1:0]           w_push_we;
   logic [IN_W-1:0]           w_we;
   logic [IDX_W-1:0]          w_wr_idx;
   logic [IN_W*ENTRY_W-1:0]   w_wr_data;
   logic [ENTRY_W-1:0]        w_rd_data;
   logic                      w_mv_en;
   logic                      w_pop;
   logic                      w_keep_avail;
   iq_act_e                   w_act;

   // Occupancy and handshake, all from registered pointers
   assign w_count   = r_wr_ptr - r_rd_ptr;
   assign w_free    = PTR_W'(DEPTH) - w_count;
   assign in_ready  = (w_free >= PTR_W'(IN_W));
   assign out_valid = (w_count != '0);
   assign empty     = ~out_valid;
   assign count     = w_count;
   assign w_pop     = out_valid & out_ready;
   assign w_push_we = in_valid & {IN_W{in_ready}};
   assign w_pop_ptr = r_rd_ptr + PTR_W'(w_pop);
   // An entry survives the pop only if more were held than are leaving
   assign w_keep_avail = (w_count > PTR_W'(w_pop));

   // Lane packing into {exc, pc, inst}
   always_comb begin
      w_wr_data = '0;
      w_push_n  = '0;
      for (int i = 0; i < int'(IN_W); i++) begin
         w_wr_data[i*ENTRY_W +: ENTRY_W] = {in_exc[i*EXC_W +: EXC_W],
                                            in_pc[i*PC_W +: PC_W],
                                            in_inst[i*INST_W +: INST_W]};
         w_push_n = w_push_n + PTR_W'(w_push_we[i]);
      end
   end

   // Cycle action by priority flush > br_kill > normal
   always_comb begin
      w_act = IQ_ACT_NORMAL;
      if (flush) begin
         w_act = IQ_ACT_CLEAR;
      end else if (br_kill) begin
         w_act = br_keep_head ? IQ_ACT_KEEP : IQ_ACT_CLEAR;
      end
   end

   // Next pointers and storage write controls
   always_comb begin
      w_rd_nxt = w_pop_ptr;
      w_wr_nxt = r_wr_ptr + w_push_n;
      w_we     = w_push_we;
      w_wr_idx = r_wr_ptr[IDX_W-1:0];
      w_mv_en  = 1'b0;
      case (w_act)
         IQ_ACT_CLEAR: begin
            w_rd_nxt = '0;
            w_wr_nxt = '0;
            w_we     = '0;
         end
         IQ_ACT_KEEP: begin
            w_rd_nxt = '0;
            w_we     = '0;
            if (w_keep_avail) begin
               // Delay-slot entry relocates to index 0
               w_mv_en  = 1'b1;
               w_wr_nxt = PTR_W'(1);
            end else if (w_push_we[0]) begin
               w_we[0]  = 1'b1;
               w_wr_idx = '0;
               w_wr_nxt = PTR_W'(1);
            end else begin
               w_wr_nxt = '0;
            end
         end
         default: ;
      endcase
   end

   // Pointer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         r_rd_ptr <= w_rd_nxt;
         r_wr_ptr <= w_wr_nxt;
      end
   end

   id_iq_ram #(
      .DEPTH   (DEPTH),
      .IN_W    (IN_W),
      .ENTRY_W (ENTRY_W)
   ) u_ram (
      .clk       (clk),
      .i_we      (w_we),
      .i_wr_idx  (w_wr_idx),
      .i_wr_data (w_wr_data),
      .i_mv_en   (w_mv_en),
      .i_mv_src  (w_pop_ptr[IDX_W-1:0]),
      .i_rd_idx  (r_rd_ptr[IDX_W-1:0]),
      .o_rd_data (w_rd_data)
   );

   // Bubble is an all-zero word
   assign out_inst = out_valid ? w_rd_data[0 +: INST_W]              : '0;
   assign out_pc   = out_valid ? w_rd_data[INST_W +: PC_W]           : '0;
   assign out_exc  = out_valid ? w_rd_data[INST_W+PC_W +: EXC_W]     : '0;

endmodule

// File: tb/tb_id_inst_queue.sv
// Self-checking bench for id_inst_queue: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_id_inst_queue;

   localparam int DEPTH = 8;
   localparam int IN_W  = 2;

   logic        clk;
   logic        rst, flush, br_kill, br_keep_head, out_ready;
   logic [1:0]  in_valid;
   logic [63:0] in_pc, in_inst, in_exc;
   logic        in_ready, out_valid, empty;
   logic [31:0] out_pc, out_inst, out_exc;
   logic [3:0]  count;

   id_inst_queue dut (
      .clk(clk), .rst(rst), .flush(flush), .br_kill(br_kill),
      .br_keep_head(br_keep_head), .in_valid(in_valid), .in_pc(in_pc),
      .in_inst(in_inst), .in_exc(in_exc), .in_ready(in_ready),
      .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
      .out_exc(out_exc), .out_ready(out_ready), .count(count), .empty(empty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0F0F;
   endfunction
   function automatic logic [31:0] exc_of(input logic [31:0] pc);
      return pc + 32'h0000_0100;
   endfunction

   // Reference model: plain FIFO of entries
   typedef struct { logic [31:0] pc; logic [31:0] inst; logic [31:0] exc; } ent_t;
   ent_t mq[$];
   ent_t e;
   int   m_sz;
   logic m_rdy, m_pop;

   always @(negedge clk) begin
      m_sz = mq.size();
      if (chk_en) begin
         chk("thermo_in_valid", 64'(in_valid[1] & ~in_valid[0]), 64'd0);
         chk("count", 64'(count), 64'(m_sz));
         chk("empty", 64'(empty), 64'(m_sz == 0));
         chk("out_valid", 64'(out_valid), 64'(m_sz != 0));
         chk("in_ready", 64'(in_ready), 64'((DEPTH - m_sz) >= IN_W));
         if (m_sz != 0) begin
            chk("out_pc", 64'(out_pc), 64'(mq[0].pc));
            chk("out_inst", 64'(out_inst), 64'(mq[0].inst));
            chk("out_exc", 64'(out_exc), 64'(mq[0].exc));
         end else begin
            chk("bubble", {out_pc, out_inst | out_exc}, 64'd0);
         end
      end
      m_rdy = (DEPTH - m_sz) >= IN_W;
      m_pop = (m_sz != 0) && out_ready;
      if (rst || flush) begin
         mq.delete();
      end else if (br_kill) begin
         if (m_pop) void'(mq.pop_front());
         if (!br_keep_head) begin
            mq.delete();
         end else if (mq.size() >= 1) begin
            while (mq.size() > 1) void'(mq.pop_back());
         end else if (in_valid[0] && m_rdy) begin
            e.pc = in_pc[31:0]; e.inst = in_inst[31:0]; e.exc = in_exc[31:0];
            mq.push_back(e);
         end
      end else begin
         if (m_pop) void'(mq.pop_front());
         if (m_rdy) begin
            for (int i = 0; i < IN_W; i++) begin
               if (in_valid[i]) begin
                  e.pc = in_pc[i*32 +: 32]; e.inst = in_inst[i*32 +: 32]; e.exc = in_exc[i*32 +: 32];
                  mq.push_back(e);
               end
            end
         end
      end
   end

   // Apply one cycle of inputs; returns at posedge+1
   task automatic drive(input logic r, input logic f, input logic k, input logic kh,
                        input logic [1:0] v, input logic [31:0] pc0, input logic ordy);
      logic [31:0] pc1;
      pc1 = pc0 + 32'd4;
      rst = r; flush = f; br_kill = k; br_keep_head = kh; in_valid = v; out_ready = ordy;
      in_pc   = {pc1, pc0};
      in_inst = {inst_of(pc1), inst_of(pc0)};
      in_exc  = {exc_of(pc1), exc_of(pc0)};
      @(posedge clk);
      #1;
   endtask

   task automatic fill5(input logic [31:0] base);
      drive(0, 0, 0, 0, 2'b11, base, 0);
      drive(0, 0, 0, 0, 2'b11, base + 32'd8, 0);
      drive(0, 0, 0, 0, 2'b01, base + 32'd16, 0);
   endtask

   logic [31:0] exp_pc, pc_n;
   logic        acc;

   initial begin
      rst = 1; flush = 0; br_kill = 0; br_keep_head = 0; in_valid = 0; out_ready = 0;
      in_pc = '0; in_inst = '0; in_exc = '0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      drive(1, 0, 0, 0, 2'b00, 32'd0, 0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_pc", 64'(out_pc), 64'd0);

      // Basic push of two, then drain one per cycle
      drive(0, 0, 0, 0, 2'b11, 32'hBFC0_0000, 1);
      chk("basic_pc0", 64'(out_pc), 64'hBFC0_0000);
      chk("basic_cnt2", 64'(count), 64'd2);
      drive(0, 0, 0, 0, 2'b00, 32'd0, 1);
      chk("basic_pc1", 64'(out_pc), 64'hBFC0_0004);
      chk("basic_cnt1", 64'(count), 64'd1);
      drive(0, 0, 0, 0, 2'b00, 32'd0, 1);
      chk("basic_cnt0", 64'(count), 64'd0);

      // Fill to DEPTH with ID stalled; fifth group is dropped
      for (int c = 0; c < 4; c++) drive(0, 0, 0, 0, 2'b11, 32'h1000 + 32'(c * 8), 0);
      chk("full_cnt", 64'(count), 64'd8);
      chk("full_ready", 64'(in_ready), 64'd0);
      drive(0, 0, 0, 0, 2'b11, 32'h2000, 0);
      chk("full_drop", 64'(count), 64'd8);
      for (int k = 0; k < 8; k++) begin
         chk("drain_order", 64'(out_pc), 64'(32'h1000 + 32'(k * 4)));
         drive(0, 0, 0, 0, 2'b00, 32'd0, 1);
      end
      chk("drain_empty", 64'(empty), 64'd1);

      // Push 2 / pop 1 across multiple pointer wraps
      exp_pc = 32'h8000; pc_n = 32'h8000;
      for (int c = 0; c < 48; c++) begin
         if (out_valid) begin chk("wrap_seq", 64'(out_pc), 64'(exp_pc)); exp_pc += 32'd4; end
         acc = in_ready;
         drive(0, 0, 0, 0, acc ? 2'b11 : 2'b00, pc_n, 1);
         if (acc) pc_n += 32'd8;
      end
      for (int c = 0; c < 16; c++) begin
         if (out_valid) begin chk("wrap_seq", 64'(out_pc), 64'(exp_pc)); exp_pc += 32'd4; end
         drive(0, 0, 0, 0, 2'b00, 32'd0, 1);
      end
      chk("wrap_total", 64'(exp_pc), 64'(pc_n));
      chk("wrap_min", 64'(pc_n > 32'h8000 + 32'd128), 64'd1);

      // Delay-slot keep with count=3 while popping
      drive(0, 0, 0, 0, 2'b11, 32'h3000, 0);
      drive(0, 0, 0, 0, 2'b01, 32'h3008, 0);
      chk("keep3_pre", 64'(count), 64'd3);
      drive(0, 0, 1, 1, 2'b11, 32'h4000, 1);
      chk("keep3_cnt", 64'(count), 64'd1);
      chk("keep3_pc", 64'(out_pc), 64'h3004);
      drive(0, 0, 0, 0, 2'b00, 32'd0, 0);
      chk("keep3_hold", 64'(out_pc), 64'h3004);

      // Delay-slot keep with count=1 while popping: lane 0 of incoming becomes head
      drive(0, 0, 1, 1, 2'b11, 32'h5000, 1);
      chk("keep1_cnt", 64'(count), 64'd1);
      chk("keep1_pc", 64'(out_pc), 64'h5000);

      // Keep without pop retains current head; kill without keep clears
      drive(0, 0, 0, 0, 2'b11, 32'h6000, 0);
      drive(0, 0, 1, 1, 2'b11, 32'h7000, 0);
      chk("keep_nopop_cnt", 64'(count), 64'd1);
      chk("keep_nopop_pc", 64'(out_pc), 64'h5000);
      drive(0, 0, 0, 0, 2'b11, 32'h6100, 0);
      drive(0, 0, 1, 0, 2'b11, 32'h7100, 1);
      chk("kill_cnt", 64'(count), 64'd0);

      // Keep from empty queue takes lane 0 only
      drive(0, 0, 1, 1, 2'b11, 32'h7200, 0);
      chk("keep_empty_cnt", 64'(count), 64'd1);
      chk("keep_empty_pc", 64'(out_pc), 64'h7200);
      drive(0, 0, 0, 0, 2'b00, 32'd0, 1);

      // Flush mid-burst at count=5
      fill5(32'h9000);
      chk("flush_pre", 64'(count), 64'd5);
      drive(0, 1, 1, 1, 2'b11, 32'h9100, 1);
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_inst", 64'(out_inst), 64'd0);
      chk("flush_cnt", 64'(count), 64'd0);
      chk("flush_ready", 64'(in_ready), 64'd1);

      // Reset mid-burst at count=5
      fill5(32'hA000);
      chk("rst_pre", 64'(count), 64'd5);
      drive(1, 0, 0, 0, 2'b11, 32'hA100, 1);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_inst", 64'(out_inst), 64'd0);
      chk("rst_cnt2", 64'(count), 64'd0);
      chk("rst_ready2", 64'(in_ready), 64'd1);

      // Resume after reset
      drive(0, 0, 0, 0, 2'b01, 32'hB000, 0);
      chk("resume_pc", 64'(out_pc), 64'hB000);
      drive(0, 0, 0, 0, 2'b00, 32'd0, 1);
      drive(0, 0, 0, 0, 2'b00, 32'd0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
